// File: rtl/single_stage_pipeline_register.sv
// One-deep valid/ready pipeline register. REG_READY=1 adds a one-word skid slot
// so that input_ready also comes from a flop, cutting the backward ready path.
module single_stage_pipeline_register #(
    parameter int DATA_WIDTH = 8,
    parameter bit REG_READY  = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] input_data,
    input  logic                  input_valid,
    output logic                  input_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  w_in_ready;
    logic                  w_xfer_in;
    logic                  w_xfer_out;
    logic                  w_main_free;

    // reset_n is active-high: the block refuses words while it is asserted.
    assign input_ready = w_in_ready & ~reset_n;
    assign w_xfer_in   = input_valid & input_ready;
    assign w_xfer_out  = r_out_valid & out_ready;
    assign w_main_free = ~r_out_valid | out_ready;
    assign out_data    = r_out_data;
    assign out_valid   = r_out_valid;

    generate
        if (REG_READY == 1'b0) begin : g_comb_ready
            assign w_in_ready = w_main_free;

            always_ff @(posedge clk) begin
                if (reset_n) begin
                    r_out_valid <= 1'b0;
                    r_out_data  <= '0;
                end else if (w_xfer_in) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= input_data;
                end else if (w_xfer_out) begin
                    r_out_valid <= 1'b0;
                end
            end
        end else begin : g_skid
            logic                  r_skid_valid;
            logic [DATA_WIDTH-1:0] r_skid_data;
            logic                  r_in_ready;
            logic                  w_out_valid_next;
            logic [DATA_WIDTH-1:0] w_out_data_next;
            logic                  w_skid_valid_next;
            logic [DATA_WIDTH-1:0] w_skid_data_next;

            assign w_in_ready = r_in_ready;

            // A full skid slot blocks input, so it always drains ahead of new words.
            always_comb begin
                w_out_valid_next  = r_out_valid;
                w_out_data_next   = r_out_data;
                w_skid_valid_next = r_skid_valid;
                w_skid_data_next  = r_skid_data;
                if (r_skid_valid) begin
                    if (out_ready) begin
                        w_out_valid_next  = 1'b1;
                        w_out_data_next   = r_skid_data;
                        w_skid_valid_next = 1'b0;
                    end
                end else if (w_xfer_in) begin
                    if (w_main_free) begin
                        w_out_valid_next = 1'b1;
                        w_out_data_next  = input_data;
                    end else begin
                        w_skid_valid_next = 1'b1;
                        w_skid_data_next  = input_data;
                    end
                end else if (w_xfer_out) begin
                    w_out_valid_next = 1'b0;
                end
            end

            always_ff @(posedge clk) begin
                if (reset_n) begin
                    r_out_valid  <= 1'b0;
                    r_out_data   <= '0;
                    r_skid_valid <= 1'b0;
                    r_skid_data  <= '0;
                    r_in_ready   <= 1'b1;
                end else begin
                    r_out_valid  <= w_out_valid_next;
                    r_out_data   <= w_out_data_next;
                    r_skid_valid <= w_skid_valid_next;
                    r_skid_data  <= w_skid_data_next;
                    r_in_ready   <= ~w_skid_valid_next;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_single_stage_pipeline_register.sv
// Directed and random stream checks of both ready modes of the pipeline register.
module tb_single_stage_pipeline_register;

    logic       clk;
    logic       rst  [2];
    logic [7:0] din  [2];
    logic       dval [2];
    logic       drdy [2];
    logic [7:0] dout [2];
    logic       oval [2];
    logic       ordy [2];

    int n_cmp;
    int n_err;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic       acc [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        single_stage_pipeline_register #(
            .DATA_WIDTH (8),
            .REG_READY  (gi[0])
        ) u_dut (
            .clk         (clk),
            .reset_n     (rst[gi]),
            .input_data  (din[gi]),
            .input_valid (dval[gi]),
            .input_ready (drdy[gi]),
            .out_data    (dout[gi]),
            .out_valid   (oval[gi]),
            .out_ready   (ordy[gi])
        );
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic directed(input int m);
        logic a;
        string p;
        p = $sformatf("m%0d_", m);
        rst[m] = 1'b1; dval[m] = 1'b0; din[m] = 8'h00; ordy[m] = 1'b1;
        step();
        check_val({p, "rst_valid"}, 32'(oval[m]), 32'd0);
        check_val({p, "rst_data"}, 32'(dout[m]), 32'h00);
        check_val({p, "rst_in_ready"}, 32'(drdy[m]), 32'd0);
        rst[m] = 1'b0;
        #1;
        check_val({p, "rel_in_ready"}, 32'(drdy[m]), 32'd1);
        step();
        check_val({p, "idle_valid"}, 32'(oval[m]), 32'd0);
        check_val({p, "idle_data"}, 32'(dout[m]), 32'h00);

        din[m] = 8'h15; dval[m] = 1'b1;
        step();
        check_val({p, "first_data"}, 32'(dout[m]), 32'h15);
        check_val({p, "first_valid"}, 32'(oval[m]), 32'd1);
        din[m] = 8'h3C;
        step();
        check_val({p, "b2b_data"}, 32'(dout[m]), 32'h3C);
        check_val({p, "b2b_valid"}, 32'(oval[m]), 32'd1);
        dval[m] = 1'b0;
        step();
        check_val({p, "drop_valid"}, 32'(oval[m]), 32'd0);
        check_val({p, "drop_hold"}, 32'(dout[m]), 32'h3C);

        din[m] = 8'hA5; dval[m] = 1'b1; ordy[m] = 1'b0;
        step();
        check_val({p, "load_a5"}, 32'(dout[m]), 32'hA5);
        din[m] = 8'h5A;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_val($sformatf("%sstall_rdy%0d", p, k), 32'(drdy[m]),
                      (k == 0 && m == 1) ? 32'd1 : 32'd0);
            a = dval[m] & drdy[m];
            step();
            if (a) dval[m] = 1'b0;
            check_val($sformatf("%sstall_data%0d", p, k), 32'(dout[m]), 32'hA5);
            check_val($sformatf("%sstall_valid%0d", p, k), 32'(oval[m]), 32'd1);
        end
        ordy[m] = 1'b1;
        step();
        check_val({p, "drain_data"}, 32'(dout[m]), 32'h5A);
        check_val({p, "drain_valid"}, 32'(oval[m]), 32'd1);
        dval[m] = 1'b0;
        #1;
        check_val({p, "drain_rdy"}, 32'(drdy[m]), 32'd1);
        step();
        check_val({p, "empty_valid"}, 32'(oval[m]), 32'd0);
        check_val({p, "empty_hold"}, 32'(dout[m]), 32'h5A);

        ordy[m] = 1'b0; din[m] = 8'hC3; dval[m] = 1'b1;
        step();
        check_val({p, "held_c3"}, 32'(dout[m]), 32'hC3);
        din[m] = 8'h99;
        step();
        dval[m] = 1'b0;
        rst[m] = 1'b1;
        #1;
        check_val({p, "midrst_rdy"}, 32'(drdy[m]), 32'd0);
        step();
        check_val({p, "midrst_valid"}, 32'(oval[m]), 32'd0);
        check_val({p, "midrst_data"}, 32'(dout[m]), 32'h00);
        rst[m] = 1'b0; ordy[m] = 1'b1;
        step();
        check_val({p, "skid_lost_valid"}, 32'(oval[m]), 32'd0);
        check_val({p, "skid_lost_data"}, 32'(dout[m]), 32'h00);
    endtask

    task automatic sample_stream(input int m, input string tag);
        logic [8:0] exp;
        if (oval[m] && ordy[m]) begin
            exp = 9'h100;
            if (m == 0) begin
                if (q0.size() != 0) exp = {1'b0, q0.pop_front()};
            end else begin
                if (q1.size() != 0) exp = {1'b0, q1.pop_front()};
            end
            check_val($sformatf("m%0d_%s", m, tag), {23'd0, 1'b0, dout[m]}, {23'd0, exp});
        end
        acc[m] = dval[m] & drdy[m];
        if (acc[m]) begin
            if (m == 0) q0.push_back(din[m]);
            else        q1.push_back(din[m]);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        for (int m = 0; m < 2; m++) begin
            rst[m] = 1'b1; din[m] = 8'h00; dval[m] = 1'b0; ordy[m] = 1'b1; acc[m] = 1'b0;
        end
        step();
        directed(0);
        directed(1);

        for (int m = 0; m < 2; m++) begin
            rst[m] = 1'b1; dval[m] = 1'b0; acc[m] = 1'b0;
        end
        step();
        for (int m = 0; m < 2; m++) rst[m] = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            step();
            for (int m = 0; m < 2; m++) begin
                ordy[m] = ($urandom_range(0, 3) != 0);
                if (!dval[m] || acc[m]) begin
                    dval[m] = ($urandom_range(0, 2) != 0);
                    din[m]  = 8'($urandom);
                end
            end
            #1;
            for (int m = 0; m < 2; m++) sample_stream(m, "stream");
        end
        for (int cyc = 0; cyc < 8; cyc++) begin
            step();
            for (int m = 0; m < 2; m++) begin
                dval[m] = 1'b0;
                ordy[m] = 1'b1;
            end
            #1;
            for (int m = 0; m < 2; m++) sample_stream(m, "flush");
        end
        check_val("m0_left_over", 32'(q0.size()), 32'd0);
        check_val("m1_left_over", 32'(q1.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
